load_store_unit: RTL

- Initiator side of the data-memory interface.
- Accepts one load/store request at a time from the execute stage and drives the word-addressed data memory port (address, write data, write enable, read enable; async read, sync write).
- Provides RV64 byte/half/word/double access: byte-lane extraction with sign/zero extension for loads, read-modify-write for sub-word stores.
- Returns the result on a valid/ready response channel.

---
 rtl/load_store_unit.sv | 129 ++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Data-memory initiator: one outstanding load/store, sub-word extract/extend on loads
// and read-modify-write for sub-word stores, result returned on a valid/ready channel.
module load_store_unit #(
  parameter int ADDR_WIDTH      = 64,
  parameter int DATA_WIDTH      = 64,
  parameter int WORD_BYTES_2POW = 3
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  req_valid_in,
  output logic                  req_ready_out,
  input  logic                  req_write_in,
  input  logic [1:0]            req_size_in,
  input  logic                  req_unsigned_in,
  input  logic [ADDR_WIDTH-1:0] req_address_in,
  input  logic [DATA_WIDTH-1:0] req_data_in,
  output logic                  resp_valid_out,
  input  logic                  resp_ready_in,
  output logic [DATA_WIDTH-1:0] resp_data_out,
  output logic                  resp_error_out,
  output logic [ADDR_WIDTH-1:0] mem_address_out,
  output logic [DATA_WIDTH-1:0] mem_data_out,
  output logic                  mem_writeEnable_out,
  output logic                  mem_readEnable_out,
  input  logic [DATA_WIDTH-1:0] mem_data_in
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int OW = WORD_BYTES_2POW;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_READ, S_WRITE, S_RESP} state_t;

  state_t                r_state, w_next;
  logic [1:0]            r_size;
  logic                  r_unsigned;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data, r_wdata, r_rdata;
  logic                  r_err;

  logic                  w_accept, w_misal, w_mem_act;
  logic [OW-1:0]         w_req_off, w_align_mask, w_off;
  logic [OW+2:0]         w_shamt;
  logic [DATA_WIDTH-1:0] w_shifted, w_ld_ext, w_sdata_sh, w_merged;
  logic [NB-1:0]         w_bmask;

  assign w_accept     = req_valid_in && (r_state == S_IDLE);
  assign w_req_off    = req_address_in[OW-1:0];
  // Low offset bits that must be zero for the requested size.
  assign w_align_mask = OW'((1 << req_size_in) - 1);
  assign w_misal      = |(w_req_off & w_align_mask);

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) begin
        if (w_misal)                 w_next = S_RESP;
        else if (!req_write_in)      w_next = S_LOAD;
        else if (req_size_in == 2'b11) w_next = S_WRITE;
        else                         w_next = S_READ;
      end
      S_LOAD:  w_next = S_RESP;
      S_READ:  w_next = S_WRITE;
      S_WRITE: w_next = S_RESP;
      S_RESP:  if (resp_ready_in) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_off      = r_addr[OW-1:0];
  assign w_shamt    = {w_off, 3'b000};
  assign w_shifted  = mem_data_in >> w_shamt;
  assign w_sdata_sh = r_data << w_shamt;
  assign w_bmask    = NB'((1 << (1 << r_size)) - 1) << w_off;

  always_comb begin
    w_ld_ext = w_shifted;
    case (r_size)
      2'b00: w_ld_ext = {{(DATA_WIDTH-8){~r_unsigned & w_shifted[7]}},   w_shifted[7:0]};
      2'b01: w_ld_ext = {{(DATA_WIDTH-16){~r_unsigned & w_shifted[15]}}, w_shifted[15:0]};
      2'b10: w_ld_ext = {{(DATA_WIDTH-32){~r_unsigned & w_shifted[31]}}, w_shifted[31:0]};
      default: w_ld_ext = w_shifted;
    endcase
  end

  // Little-endian lane merge: selected lanes take shifted store data, others keep memory.
  for (genvar k = 0; k < NB; k++) begin : g_lane
    assign w_merged[8*k +: 8] = w_bmask[k] ? w_sdata_sh[8*k +: 8] : mem_data_in[8*k +: 8];
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_size     <= '0;
      r_unsigned <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_size     <= req_size_in;
        r_unsigned <= req_unsigned_in;
        r_addr     <= req_address_in;
        r_data     <= req_data_in;
        r_wdata    <= req_data_in;  // double stores write this verbatim
        r_rdata    <= '0;
        r_err      <= w_misal;
      end
      if (r_state == S_LOAD) r_rdata <= w_ld_ext;
      if (r_state == S_READ) r_wdata <= w_merged;
    end
  end

  // Memory port is decoded purely from state and latched fields.
  assign w_mem_act           = (r_state == S_LOAD) || (r_state == S_READ) || (r_state == S_WRITE);
  assign mem_readEnable_out  = (r_state == S_LOAD) || (r_state == S_READ);
  assign mem_writeEnable_out = (r_state == S_WRITE);
  assign mem_address_out     = w_mem_act ? {r_addr[ADDR_WIDTH-1:OW], {OW{1'b0}}} : '0;
  assign mem_data_out        = (r_state == S_WRITE) ? r_wdata : '0;

  assign req_ready_out  = (r_state == S_IDLE);
  assign resp_valid_out = (r_state == S_RESP);
  assign resp_data_out  = (r_state == S_RESP) ? r_rdata : '0;
  assign resp_error_out = (r_state == S_RESP) && r_err;
endmodule
